// File: rtl/queue_pkg.sv
// Shared sizing for the queue controller and its 1024x8 single-port RAM.
package queue_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned COUNT_W = ADDR_W + 1;

endpackage : queue_pkg

// File: rtl/queue_ptr.sv
// Wrapping RAM pointer; advances by one when i_inc is set, wraps modulo 2**W.
module queue_ptr
  import queue_pkg::*;
#(
  parameter int unsigned W = ADDR_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ptr <= '0;
    end else if (i_inc) begin
      o_ptr <= o_ptr + W'(1);
    end
  end

endmodule : queue_ptr

// File: rtl/queue_ctrl.sv
// Push/pop front end for a single-port queue RAM: fair arbitration, pointers,
// occupancy, registered RAM commands and registered read return.
module queue_ctrl
  import queue_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               push_i,
  input  logic [DATA_W-1:0]  push_data_i,
  output logic               push_ready_o,
  input  logic               pop_i,
  output logic               pop_ready_o,
  output logic [DATA_W-1:0]  pop_data_o,
  output logic               pop_valid_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [COUNT_W-1:0] count_o,
  output logic [ADDR_W-1:0]  ram_addr_o,
  output logic [DATA_W-1:0]  ram_wdata_o,
  output logic               ram_wen_o,
  output logic               ram_oen_o,
  input  logic [DATA_W-1:0]  ram_rdata_i
);

  logic                w_push_ok;
  logic                w_pop_ok;
  logic                w_grant_push;
  logic                w_grant_pop;
  logic [ADDR_W-1:0]   w_wr_ptr;
  logic [ADDR_W-1:0]   w_rd_ptr;
  logic [COUNT_W-1:0]  w_count_nxt;
  logic [COUNT_W-1:0]  r_count;
  logic                r_full;
  logic                r_empty;
  logic                r_prio;

  // Eligibility and arbitration; r_prio breaks ties (0 = push, 1 = pop).
  always_comb begin
    w_push_ok    = push_i && !r_full;
    w_pop_ok     = pop_i && !r_empty;
    w_grant_push = w_push_ok && (!w_pop_ok || !r_prio);
    w_grant_pop  = w_pop_ok && (!w_push_ok || r_prio);
    push_ready_o = !r_full && !(w_pop_ok && r_prio);
    pop_ready_o  = !r_empty && !(w_push_ok && !r_prio);
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_grant_push) begin
      w_count_nxt = r_count + COUNT_W'(1);
    end else if (w_grant_pop) begin
      w_count_nxt = r_count - COUNT_W'(1);
    end
  end

  queue_ptr #(.W(ADDR_W)) u_wr_ptr (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_inc   (w_grant_push),
    .o_ptr   (w_wr_ptr)
  );

  queue_ptr #(.W(ADDR_W)) u_rd_ptr (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_inc   (w_grant_pop),
    .o_ptr   (w_rd_ptr)
  );

  // Occupancy, flags and tie-break state; flags follow the registered count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_prio  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == COUNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (w_push_ok && w_pop_ok) begin
        r_prio <= !r_prio;
      end
    end
  end

  // RAM command stage; address and write data hold on idle cycles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      ram_wen_o   <= 1'b0;
      ram_oen_o   <= 1'b0;
    end else begin
      ram_wen_o <= w_grant_push;
      ram_oen_o <= w_grant_pop;
      if (w_grant_push) begin
        ram_addr_o  <= w_wr_ptr;
        ram_wdata_o <= push_data_i;
      end else if (w_grant_pop) begin
        ram_addr_o <= w_rd_ptr;
      end
    end
  end

  // Read return: capture RAM output during the read cycle, strobe once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pop_data_o  <= '0;
      pop_valid_o <= 1'b0;
    end else begin
      pop_valid_o <= ram_oen_o;
      if (ram_oen_o) begin
        pop_data_o <= ram_rdata_i;
      end
    end
  end

  assign count_o = r_count;
  assign full_o  = r_full;
  assign empty_o = r_empty;

endmodule : queue_ctrl
